out_stream_arbiter: RTL and testbench
=====================================

// Module: out_stream_arbiter
// PURPOSE
// - Shares the single 32-bit USB output stream (o_out_data/vld/rdy) between two packet sources:
//   A = frame_header output (scope frames), B = status/command-response packets.
// - Packet-atomic arbitration: a grant holds until the full declared word count has passed.
// - Sits in the sys_clk domain, between frame_header / status source and the top-level out port.
// PARAMETERS
// - A_BURST_MAX  4     consecutive A packets allowed while B is pending before B is forced in
// - TIMEOUT      1023  clk cycles a granted source may hold vld low mid-packet before abort (0 = off)
// PORTS
// - clk          in   1   system clock (sys_clk)
// - rst_n        in   1   asynchronous active-low reset
// - i_a_req      in   1   A has a packet; level, held until o_a_done
// - i_a_len      in   16  A packet length in 32-bit words; sampled at grant
// - i_a_data     in   32  A stream data
// - i_a_vld      in   1   A stream valid
// - o_a_rdy      out  1   A stream ready
// - o_a_done     out  1   one-cycle pulse: A packet finished (or aborted)
// - i_b_req/i_b_len/i_b_data/i_b_vld, o_b_rdy/o_b_done: same for B
// - o_out_data   out  32  muxed output data
// - o_out_vld    out  1   muxed output valid
// - i_out_rdy    in   1   downstream ready
// - o_owner      out  2   0 none, 1 A, 2 B
// - o_timeout    out  1   one-cycle pulse: packet aborted by TIMEOUT
// BEHAVIOUR
// - Reset: state IDLE, o_owner=0, o_out_vld=0, o_out_data=0, o_a/b_rdy=0, o_a/b_done=0,
//   o_timeout=0, word/idle/burst counters 0.
// - States: IDLE, GRANT_A, GRANT_B, DONE.
// - IDLE: pick winner from reqs sampled this cycle; latch len into remain[15:0]; go GRANT_x next cycle.
//   Winner: A if i_a_req and not (i_b_req and burst_cnt>=A_BURST_MAX); else B if i_b_req.
// - burst_cnt: +1 (saturating) at each A grant while i_b_req=1; cleared at every B grant and when i_b_req=0.
// - Zero len: IDLE->DONE directly, no data transfer, done pulse still issued.
// - GRANT_x: o_out_data/o_out_vld = source x data/vld (combinational mux on registered owner);
//   o_x_rdy = i_out_rdy; other source rdy = 0. Transfer = vld & rdy; remain -1 per transfer.
//   Transfer with remain==1 -> DONE. No extra data beyond len is accepted.
// - Timeout: idle_cnt counts cycles in GRANT_x with x_vld=0, cleared on any vld; reaching TIMEOUT
//   -> o_timeout pulse, DONE (packet truncated, no padding).
// - DONE: one cycle; o_x_done=1, owner=0, all rdy=0, o_out_vld=0; -> IDLE. Source must drop req
//   on o_x_done or it is re-arbitrated as a new packet. Min gap between packets: 2 cycles.
// - Req dropped mid-grant: ignored; packet completes by count or timeout.
// - Both reqs asserted in IDLE with burst_cnt<A_BURST_MAX: A wins.
// - remain is 16-bit unsigned; len 0xFFFF transfers 65535 words, no wrap.
// - rst_n asserted mid-packet: immediate return to reset values; no done pulse.
// STRUCTURE
// - Shared package dscope_pkg: owner codes (OWN_NONE/A/B), state enum, WORD_W=32, LEN_W=16.
// - Single module; no sub-module (mux + FSM + three counters). Optional reuse of a generic
//   packet_counter is not required.
// TESTING
// - A only, len=4, i_out_rdy=1: 4 words out in 4 cycles, o_a_done 1 cycle after last, owner 1->0.
// - Both req in IDLE, A len=2, B len=1: A packet fully first, then B; B never interleaved in A.
// - A req continuously (len=1), B req held: with A_BURST_MAX=4, grants A,A,A,A,B,A...
// - i_out_rdy toggling 1,0,1,0 during len=3: exactly 3 transfers, data order preserved, no drop/dup.
// - A granted len=8, vld stops after 3 words, TIMEOUT=16: o_timeout and o_a_done after 16 idle cycles.
// - Zero-length B, and rst_n pulse mid A packet: done pulse without data; reset returns all outputs to 0.

Source files
------------

// File: rtl/dscope_pkg.sv
// Shared definitions for the scope data path: stream widths, owner codes,
// arbiter state encoding and a small saturating-counter helper.
package dscope_pkg;

    localparam int WORD_W  = 32;
    localparam int LEN_W   = 16;
    localparam int BURST_W = 8;

    // Which packet source currently drives the output stream
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    // Output-stream arbiter states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_e;

    // Increment that sticks at lim instead of wrapping
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v,
                                                   input logic [BURST_W-1:0] lim);
        logic [BURST_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + {{(BURST_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/out_stream_arbiter.sv
// Packet-atomic arbiter sharing the 32-bit USB output stream between the
// frame_header source (A) and the status/response source (B). A grant lasts
// until the declared word count has moved, or until the granted source has
// stalled for TIMEOUT cycles. A is preferred, but after A_BURST_MAX A packets
// in a row with B waiting, B is forced in.
module out_stream_arbiter
    import dscope_pkg::*;
#(
    parameter int unsigned A_BURST_MAX = 4,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_a_req,
    input  logic [LEN_W-1:0]  i_a_len,
    input  logic [WORD_W-1:0] i_a_data,
    input  logic              i_a_vld,
    output logic              o_a_rdy,
    output logic              o_a_done,
    input  logic              i_b_req,
    input  logic [LEN_W-1:0]  i_b_len,
    input  logic [WORD_W-1:0] i_b_data,
    input  logic              i_b_vld,
    output logic              o_b_rdy,
    output logic              o_b_done,
    output logic [WORD_W-1:0] o_out_data,
    output logic              o_out_vld,
    input  logic              i_out_rdy,
    output logic [1:0]        o_owner,
    output logic              o_timeout
);

    localparam logic [BURST_W-1:0] BURST_LIM  = BURST_W'(A_BURST_MAX);
    localparam logic               TIMEOUT_EN = (TIMEOUT != 32'd0);
    // Last idle count value before the abort fires (only meaningful when enabled)
    localparam logic [LEN_W-1:0]   IDLE_LAST  = LEN_W'(TIMEOUT - 32'd1);

    arb_state_e         state_q,   state_d;
    owner_e             owner_q,   owner_d;
    logic [LEN_W-1:0]   remain_q,  remain_d;
    logic [LEN_W-1:0]   idle_q,    idle_d;
    logic [BURST_W-1:0] burst_q,   burst_d;
    logic               a_done_q,  a_done_d;
    logic               b_done_q,  b_done_d;
    logic               timeout_q, timeout_d;

    logic               a_win_s;
    logic               src_vld_s;
    logic               xfer_s;
    logic               in_grant_s;

    // Winner selection and transfer qualification for the current cycle
    always_comb begin
        a_win_s    = i_a_req && !(i_b_req && (burst_q >= BURST_LIM));
        in_grant_s = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B);
        if (state_q == ST_GRANT_A) begin
            src_vld_s = i_a_vld;
        end else if (state_q == ST_GRANT_B) begin
            src_vld_s = i_b_vld;
        end else begin
            src_vld_s = 1'b0;
        end
        xfer_s = in_grant_s && src_vld_s && i_out_rdy;
    end

    // Next-state logic: arbitration, word counting, stall abort and done pulses
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        remain_d  = remain_q;
        idle_d    = idle_q;
        burst_d   = i_b_req ? burst_q : {BURST_W{1'b0}};
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle_d = {LEN_W{1'b0}};
                if (a_win_s) begin
                    burst_d  = i_b_req ? sat_inc(burst_q, BURST_LIM) : {BURST_W{1'b0}};
                    remain_d = i_a_len;
                    if (i_a_len == {LEN_W{1'b0}}) begin
                        state_d  = ST_DONE;
                        a_done_d = 1'b1;
                    end else begin
                        state_d = ST_GRANT_A;
                        owner_d = OWN_A;
                    end
                end else if (i_b_req) begin
                    burst_d  = {BURST_W{1'b0}};
                    remain_d = i_b_len;
                    if (i_b_len == {LEN_W{1'b0}}) begin
                        state_d  = ST_DONE;
                        b_done_d = 1'b1;
                    end else begin
                        state_d = ST_GRANT_B;
                        owner_d = OWN_B;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT_A, ST_GRANT_B: begin
                if (xfer_s) begin
                    remain_d = remain_q - {{(LEN_W-1){1'b0}}, 1'b1};
                end else begin
                    remain_d = remain_q;
                end
                if (src_vld_s) begin
                    idle_d = {LEN_W{1'b0}};
                end else if (TIMEOUT_EN) begin
                    idle_d = idle_q + {{(LEN_W-1){1'b0}}, 1'b1};
                end else begin
                    idle_d = {LEN_W{1'b0}};
                end
                if (xfer_s && (remain_q == {{(LEN_W-1){1'b0}}, 1'b1})) begin
                    state_d  = ST_DONE;
                    owner_d  = OWN_NONE;
                    a_done_d = (state_q == ST_GRANT_A);
                    b_done_d = (state_q == ST_GRANT_B);
                end else if (TIMEOUT_EN && !src_vld_s && (idle_q == IDLE_LAST)) begin
                    state_d   = ST_DONE;
                    owner_d   = OWN_NONE;
                    timeout_d = 1'b1;
                    a_done_d  = (state_q == ST_GRANT_A);
                    b_done_d  = (state_q == ST_GRANT_B);
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State, counters and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            remain_q  <= {LEN_W{1'b0}};
            idle_q    <= {LEN_W{1'b0}};
            burst_q   <= {BURST_W{1'b0}};
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            remain_q  <= remain_d;
            idle_q    <= idle_d;
            burst_q   <= burst_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            timeout_q <= timeout_d;
        end
    end

    // Stream mux steered by the registered owner; idle stream drives zeros
    always_comb begin
        o_out_data = {WORD_W{1'b0}};
        o_out_vld  = 1'b0;
        o_a_rdy    = 1'b0;
        o_b_rdy    = 1'b0;
        case (owner_q)
            OWN_A: begin
                o_out_data = i_a_data;
                o_out_vld  = i_a_vld;
                o_a_rdy    = i_out_rdy;
            end
            OWN_B: begin
                o_out_data = i_b_data;
                o_out_vld  = i_b_vld;
                o_b_rdy    = i_out_rdy;
            end
            default: begin
                o_out_data = {WORD_W{1'b0}};
                o_out_vld  = 1'b0;
            end
        endcase
    end

    assign o_owner   = owner_q;
    assign o_a_done  = a_done_q;
    assign o_b_done  = b_done_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_out_stream_arbiter.sv
// Self-checking bench for out_stream_arbiter: a packet-level reference model
// predicts every output each cycle, and directed scenarios pin key timings
// and data orderings with literal expectations.
module tb_out_stream_arbiter;

    localparam int BMAX = 4;
    localparam int TMO  = 16;
    localparam logic [31:0] A_BASE = 32'hA000_0000;
    localparam logic [31:0] B_BASE = 32'hB000_0000;

    logic        clk;
    logic        rst_n;
    logic        a_req, b_req, a_vld, b_vld, out_rdy;
    logic [15:0] a_len, b_len;
    logic [31:0] a_data, b_data;
    logic        a_rdy, b_rdy, a_done, b_done, out_vld, tmo;
    logic [31:0] out_data;
    logic [1:0]  owner;

    out_stream_arbiter #(.A_BURST_MAX(BMAX), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_a_req(a_req), .i_a_len(a_len), .i_a_data(a_data), .i_a_vld(a_vld),
        .o_a_rdy(a_rdy), .o_a_done(a_done),
        .i_b_req(b_req), .i_b_len(b_len), .i_b_data(b_data), .i_b_vld(b_vld),
        .o_b_rdy(b_rdy), .o_b_done(b_done),
        .o_out_data(out_data), .o_out_vld(out_vld), .i_out_rdy(out_rdy),
        .o_owner(owner), .o_timeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // source behaviour
    int a_idx = 0, b_idx = 0;
    int a_lim = 100000, b_lim = 100000;
    bit a_drop = 1'b1, b_drop = 1'b1;

    // observation logs
    logic [31:0] q_out[$];
    logic [1:0]  q_grant[$];
    logic [1:0]  prev_own = 2'd0;
    int first_xfer, last_xfer, a_done_cyc, b_done_cyc, to_cyc;
    int n_xfer, n_adone, n_bdone, n_to;

    // reference model: who owns the stream, words left, stall and burst counts
    int m_own = 0, m_left = 0, m_idle = 0, m_burst = 0, m_fin = 0;
    bit m_to = 1'b0;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic clear_logs();
        q_out.delete(); q_grant.delete();
        first_xfer = -1; last_xfer = -1; a_done_cyc = -1; b_done_cyc = -1; to_cyc = -1;
        n_xfer = 0; n_adone = 0; n_bdone = 0; n_to = 0;
    endtask

    task automatic check_cycle();
        logic [1:0]  e_own;
        logic [31:0] e_data;
        logic        e_vld, e_ardy, e_brdy, e_ad, e_bd, e_to;
        e_own = 2'd0; e_data = 32'd0; e_vld = 1'b0; e_ardy = 1'b0; e_brdy = 1'b0;
        e_ad = 1'b0; e_bd = 1'b0; e_to = 1'b0;
        if (rst_n) begin
            e_own = 2'(m_own);
            if (m_own == 1) begin e_vld = a_vld; e_data = a_data; e_ardy = out_rdy; end
            if (m_own == 2) begin e_vld = b_vld; e_data = b_data; e_brdy = out_rdy; end
            e_ad = (m_fin == 1);
            e_bd = (m_fin == 2);
            e_to = m_to;
        end
        n_chk++;
        if ({owner, out_vld, out_data, a_rdy, b_rdy, a_done, b_done, tmo} !==
            {e_own, e_vld, e_data, e_ardy, e_brdy, e_ad, e_bd, e_to}) begin
            $display("FAIL cycle%0d: own/vld/data/ardy/brdy/adone/bdone/tmo got %0d %b %h %b %b %b %b %b, expected %0d %b %h %b %b %b %b %b",
                     cyc, owner, out_vld, out_data, a_rdy, b_rdy, a_done, b_done, tmo,
                     e_own, e_vld, e_data, e_ardy, e_brdy, e_ad, e_bd, e_to);
        end else begin
            n_pass++;
        end
    endtask

    // advance the reference model across the coming clock edge
    task automatic model_step();
        int win, n;
        bit v;
        if (!rst_n) begin
            m_own = 0; m_left = 0; m_idle = 0; m_burst = 0; m_fin = 0; m_to = 1'b0;
            return;
        end
        if (m_fin != 0) begin
            m_fin = 0; m_to = 1'b0;
        end else if (m_own == 0) begin
            win = 0;
            if (a_req && !(b_req && m_burst >= BMAX)) win = 1;
            else if (b_req) win = 2;
            if (win == 1) m_burst = m_burst + 1;
            if (win == 2) m_burst = 0;
            if (win != 0) begin
                n = (win == 1) ? int'(a_len) : int'(b_len);
                if (n == 0) m_fin = win;
                else begin m_own = win; m_left = n; m_idle = 0; end
            end
        end else begin
            v = (m_own == 1) ? a_vld : b_vld;
            if (v && out_rdy) m_left--;
            if (v) m_idle = 0; else m_idle++;
            if (m_left == 0) begin
                m_fin = m_own; m_own = 0;
            end else if (m_idle == TMO) begin
                m_fin = m_own; m_own = 0; m_to = 1'b1;
            end
        end
        if (!b_req) m_burst = 0;
    endtask

    // one clock cycle: present source data, check, log, model, then let sources react
    task automatic tick();
        bit ax, bx, ad, bd;
        a_data = A_BASE + 32'(a_idx);
        b_data = B_BASE + 32'(b_idx);
        a_vld  = a_req && (a_idx < a_lim);
        b_vld  = b_req && (b_idx < b_lim);
        #1;
        check_cycle();
        if (out_vld && out_rdy) begin
            q_out.push_back(out_data);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            n_xfer++;
        end
        if (owner != 2'd0 && prev_own == 2'd0) q_grant.push_back(owner);
        prev_own = owner;
        if (a_done) begin a_done_cyc = cyc; n_adone++; end
        if (b_done) begin b_done_cyc = cyc; n_bdone++; end
        if (tmo) begin to_cyc = cyc; n_to++; end
        ax = a_vld && a_rdy; bx = b_vld && b_rdy; ad = a_done; bd = b_done;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            a_idx = 0; b_idx = 0;
        end else begin
            if (ax) a_idx++;
            if (bx) b_idx++;
            if (ad) begin a_idx = 0; if (a_drop) a_req = 1'b0; end
            if (bd) begin b_idx = 0; if (b_drop) b_req = 1'b0; end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int start;
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; a_len = 16'd0; b_len = 16'd0;
        a_data = 32'd0; b_data = 32'd0; a_vld = 1'b0; b_vld = 1'b0; out_rdy = 1'b1;
        clear_logs();
        @(negedge clk);
        ticks(3);
        lit("reset_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // A only, len 4
        clear_logs();
        a_req = 1'b1; a_len = 16'd4; start = cyc;
        ticks(9);
        lit("t1_words", 32'(n_xfer), 32'd4);
        for (int i = 0; i < 4; i++)
            lit("t1_data", (i < q_out.size()) ? q_out[i] : 32'hDEAD_BEEF, A_BASE + 32'(i));
        lit("t1_latency", 32'(first_xfer - start), 32'd1);
        lit("t1_back_to_back", 32'(last_xfer - first_xfer), 32'd3);
        lit("t1_done_after_last", 32'(a_done_cyc - last_xfer), 32'd1);

        // both request: A len 2 completes before B len 1
        clear_logs();
        a_req = 1'b1; a_len = 16'd2; b_req = 1'b1; b_len = 16'd1;
        ticks(12);
        lit("t2_words", 32'(q_out.size()), 32'd3);
        lit("t2_w0", (q_out.size() > 0) ? q_out[0] : 32'hDEAD_BEEF, A_BASE);
        lit("t2_w1", (q_out.size() > 1) ? q_out[1] : 32'hDEAD_BEEF, A_BASE + 32'd1);
        lit("t2_w2", (q_out.size() > 2) ? q_out[2] : 32'hDEAD_BEEF, B_BASE);
        lit("t2_grants", 32'(q_grant.size()), 32'd2);

        // burst limit: A continuous len 1, B waiting
        clear_logs();
        a_drop = 1'b0; a_req = 1'b1; a_len = 16'd1; b_req = 1'b1; b_len = 16'd1;
        for (int i = 0; i < 60 && q_grant.size() < 6; i++) tick();
        a_drop = 1'b1;
        ticks(6);
        lit("t3_grant_count", 32'(q_grant.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++)
            lit("t3_grant_seq", (i < q_grant.size()) ? 32'(q_grant[i]) : 32'd9,
                (i == 4) ? 32'd2 : 32'd1);

        // downstream ready toggling during a 3-word packet
        clear_logs();
        a_req = 1'b1; a_len = 16'd3;
        for (int i = 0; i < 14; i++) begin
            out_rdy = (i % 2 == 0);
            tick();
        end
        out_rdy = 1'b1;
        lit("t4_words", 32'(n_xfer), 32'd3);
        for (int i = 0; i < 3; i++)
            lit("t4_data", (i < q_out.size()) ? q_out[i] : 32'hDEAD_BEEF, A_BASE + 32'(i));

        // stall after 3 of 8 words: abort after TMO idle cycles
        clear_logs();
        a_req = 1'b1; a_len = 16'd8; a_lim = 3;
        ticks(28);
        a_lim = 100000;
        lit("t5_words", 32'(n_xfer), 32'd3);
        lit("t5_timeout_pulses", 32'(n_to), 32'd1);
        lit("t5_timeout_delay", 32'(to_cyc - last_xfer), 32'd17);
        lit("t5_done_with_timeout", 32'(a_done_cyc), 32'(to_cyc));

        // zero-length B
        clear_logs();
        b_req = 1'b1; b_len = 16'd0; start = cyc;
        ticks(5);
        lit("t6_no_data", 32'(n_xfer), 32'd0);
        lit("t6_done_count", 32'(n_bdone), 32'd1);
        lit("t6_done_delay", 32'(b_done_cyc - start), 32'd1);

        // reset in the middle of an A packet
        clear_logs();
        a_req = 1'b1; a_len = 16'd8;
        ticks(4);
        rst_n = 1'b0; a_req = 1'b0;
        tick();
        lit("t7_rst_owner", 32'(owner), 32'd0);
        lit("t7_rst_vld", 32'(out_vld), 32'd0);
        ticks(1);
        rst_n = 1'b1;
        ticks(4);
        lit("t7_words_before_rst", 32'(n_xfer), 32'd3);
        lit("t7_no_done", 32'(n_adone), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
